// File: rtl/vend_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vend_sequencer
//  Description : Front-end controller for a four-item vending datapath.
//                Accumulates coin credit, arbitrates item requests
//                round-robin, issues single-cycle Buy pulses, tracks stock,
//                enforces a dispense hold-off and refunds credit on cancel.
//  Revision    : 1.0  initial release
// ============================================================================
module vend_sequencer #(
  parameter int COST0       = 5,
  parameter int COST1       = 10,
  parameter int COST2       = 15,
  parameter int COST3       = 30,
  parameter int STOCK0      = 6,
  parameter int STOCK1      = 2,
  parameter int STOCK2      = 1,
  parameter int STOCK3      = 1,
  parameter int MAX_CREDIT  = 95,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Nickel,
  input  logic       Dime,
  input  logic       Quarter,
  input  logic [3:0] Select,
  input  logic       Cancel,
  output logic [6:0] Money,
  output logic [3:0] Buy,
  output logic [3:0] Deny,
  output logic [6:0] Change,
  output logic       ChangeValid,
  output logic       CoinReject,
  output logic       Busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
  localparam logic [7:0]    MAX_C     = 8'(MAX_CREDIT);

  localparam logic [6:0] COST [4] = '{7'(COST0), 7'(COST1), 7'(COST2), 7'(COST3)};
  localparam logic [3:0] STOCK_INIT [4] =
    '{4'(STOCK0), 4'(STOCK1), 4'(STOCK2), 4'(STOCK3)};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_HOLD    = 3'd3,
    S_REFUND  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      money_q, money_d;
  logic [3:0]      buy_q, buy_d;
  logic [3:0]      deny_q, deny_d;
  logic [6:0]      change_q, change_d;
  logic            change_valid_q, change_valid_d;
  logic            coin_reject_q, coin_reject_d;
  logic            busy_q, busy_d;
  logic [3:0]      stock_q [4];
  logic [3:0]      stock_d [4];
  logic [1:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic [7:0]      coin_sum;
  logic            coin_any;
  logic [3:0]      eligible;
  logic            found;
  logic [1:0]      gnt_idx;
  logic [1:0]      scan_idx;
  logic [7:0]      base_credit;
  logic [7:0]      new_credit;

  // Coin total, eligibility on pre-edge credit, and round-robin grant search
  always_comb begin
    coin_sum = (Nickel  ? 8'd5  : 8'd0)
             + (Dime    ? 8'd10 : 8'd0)
             + (Quarter ? 8'd25 : 8'd0);
    coin_any = Nickel | Dime | Quarter;
    for (int i = 0; i < 4; i++) begin
      eligible[i] = Select[i] && (stock_q[i] != 4'd0) && (money_q >= COST[i]);
    end
    found    = 1'b0;
    gnt_idx  = ptr_q;
    scan_idx = ptr_q;
    // Search starts just after the last winner so every item gets a turn
    for (int k = 1; k <= 4; k++) begin
      scan_idx = 2'(32'(ptr_q) + k);
      if (!found && eligible[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d        = state_q;
    money_d        = money_q;
    buy_d          = 4'd0;
    deny_d         = 4'd0;
    change_d       = change_q;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;
    stock_d        = stock_q;
    ptr_d          = ptr_q;
    hold_d         = hold_q;
    base_credit    = {1'b0, money_q};
    new_credit     = base_credit;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        deny_d = Select & ~eligible;
        if (state_q == S_COLLECT && Cancel) begin
          // Cancel beats both a grant and coins arriving in the same cycle
          state_d        = S_REFUND;
          change_d       = money_q;
          change_valid_d = 1'b1;
          coin_reject_d  = coin_any;
        end else begin
          if (state_q == S_COLLECT && found) begin
            base_credit      = base_credit - {1'b0, COST[gnt_idx]};
            buy_d            = 4'(1) << gnt_idx;
            stock_d[gnt_idx] = stock_q[gnt_idx] - 4'd1;
            ptr_d            = gnt_idx;
            state_d          = S_VEND;
          end
          new_credit = base_credit + coin_sum;
          if (coin_any && new_credit <= MAX_C) begin
            money_d = new_credit[6:0];
            if (state_d == S_IDLE) state_d = S_COLLECT;
          end else begin
            // Over-ceiling coins are refused as a whole
            money_d       = base_credit[6:0];
            coin_reject_d = coin_any;
          end
        end
      end
      S_VEND: begin
        coin_reject_d = coin_any;
        hold_d        = HOLD_INIT;
        state_d       = S_HOLD;
      end
      S_HOLD: begin
        coin_reject_d = coin_any;
        if (hold_q == '0) begin
          state_d = (money_q != 7'd0) ? S_COLLECT : S_IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_REFUND: begin
        coin_reject_d = coin_any;
        money_d       = 7'd0;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_VEND) || (state_d == S_HOLD) || (state_d == S_REFUND);
  end

  // State and output registers with asynchronous reset to power-on values
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      money_q        <= 7'd0;
      buy_q          <= 4'd0;
      deny_q         <= 4'd0;
      change_q       <= 7'd0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
      ptr_q          <= 2'd3;
      hold_q         <= '0;
      for (int i = 0; i < 4; i++) stock_q[i] <= STOCK_INIT[i];
    end else begin
      state_q        <= state_d;
      money_q        <= money_d;
      buy_q          <= buy_d;
      deny_q         <= deny_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
      busy_q         <= busy_d;
      ptr_q          <= ptr_d;
      hold_q         <= hold_d;
      for (int i = 0; i < 4; i++) stock_q[i] <= stock_d[i];
    end
  end

  assign Money       = money_q;
  assign Buy         = buy_q;
  assign Deny        = deny_q;
  assign Change      = change_q;
  assign ChangeValid = change_valid_q;
  assign CoinReject  = coin_reject_q;
  assign Busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vend_sequencer
//  Description : Directed self-checking bench for vend_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vend_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Nickel = 1'b0, Dime = 1'b0, Quarter = 1'b0, Cancel = 1'b0;
  logic [3:0] Select = 4'd0;
  logic [6:0] Money, Change;
  logic [3:0] Buy, Deny;
  logic       ChangeValid, CoinReject, Busy;

  int n_checks = 0;
  int n_fail   = 0;

  vend_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Nickel(Nickel), .Dime(Dime),
    .Quarter(Quarter), .Select(Select), .Cancel(Cancel), .Money(Money),
    .Buy(Buy), .Deny(Deny), .Change(Change), .ChangeValid(ChangeValid),
    .CoinReject(CoinReject), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic coin(input logic n, input logic d, input logic q);
    Nickel = n; Dime = d; Quarter = q;
    tick();
    Nickel = 0; Dime = 0; Quarter = 0;
  endtask

  initial begin
    // Asynchronous reset takes effect before any clock edge
    #2;
    check_val("rst_money", Money, 0);
    check_val("rst_buy", Buy, 0);
    check_val("rst_busy", Busy, 0);
    check_val("rst_change", Change, 0);
    tick(); tick();
    Reset = 0;

    // Scenario 1: 25 + 10 = 35, buy item 3 (30)
    coin(0, 0, 1);
    check_val("s1_q", Money, 25);
    coin(0, 1, 0);
    check_val("s1_d", Money, 35);
    Select = 4'b1000;
    tick();
    Select = 4'b0000;
    check_val("s1_buy", Buy, 4'b1000);
    check_val("s1_money", Money, 5);
    check_val("s1_busy_vend", Busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("s1_buy_clr", Buy, 0);
      check_val("s1_busy_hold", Busy, 1);
    end
    tick();
    check_val("s1_busy_end", Busy, 0);
    check_val("s1_money_end", Money, 5);

    // Scenario 2: 30 credit, Select 0011 held -> item0 then item1
    coin(0, 0, 1);
    check_val("s2_money", Money, 30);
    Select = 4'b0011;
    tick();
    check_val("s2_buy0", Buy, 4'b0001);
    check_val("s2_money0", Money, 25);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("s2_hold_nobuy", Buy, 0);
      check_val("s2_hold_nodeny", Deny, 0);
    end
    tick();
    check_val("s2_collect_nobuy", Buy, 0);
    tick();
    check_val("s2_buy1", Buy, 4'b0010);
    check_val("s2_money1", Money, 15);
    Select = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    check_val("s2_idle_busy", Busy, 0);

    // Scenario 3: exhaust item 2, then request it again
    Select = 4'b0100;
    tick();
    Select = 4'b0000;
    check_val("s3_buy2", Buy, 4'b0100);
    check_val("s3_money", Money, 0);
    for (int i = 0; i < 5; i++) tick();
    coin(0, 1, 0);
    coin(1, 0, 0);
    check_val("s3_credit", Money, 15);
    Select = 4'b0100;
    tick();
    Select = 4'b0000;
    check_val("s3_deny", Deny, 4'b0100);
    check_val("s3_nobuy", Buy, 0);
    check_val("s3_money_keep", Money, 15);
    tick();
    check_val("s3_deny_clr", Deny, 0);

    // Scenario 4: ceiling rejection, then coin during HOLD
    coin(0, 0, 1);
    coin(0, 0, 1);
    coin(0, 0, 1);
    check_val("s4_money90", Money, 90);
    coin(0, 0, 1);
    check_val("s4_reject", CoinReject, 1);
    check_val("s4_money_keep", Money, 90);
    tick();
    check_val("s4_reject_clr", CoinReject, 0);
    Select = 4'b0001;
    tick();
    Select = 4'b0000;
    check_val("s4_buy", Buy, 4'b0001);
    check_val("s4_money85", Money, 85);
    tick();
    coin(0, 0, 1);
    check_val("s4_hold_reject", CoinReject, 1);
    check_val("s4_hold_money", Money, 85);
    tick(); tick(); tick();
    check_val("s4_hold_end", Busy, 0);

    // Scenario 5: refund 85, then cancel with Select and coin in same cycle
    Cancel = 1;
    tick();
    Cancel = 0;
    check_val("s5_chg85", Change, 85);
    check_val("s5_cv85", ChangeValid, 1);
    tick();
    check_val("s5_money0", Money, 0);
    check_val("s5_cv_clr", ChangeValid, 0);
    coin(0, 1, 0);
    coin(0, 1, 0);
    check_val("s5_money20", Money, 20);
    Cancel = 1; Select = 4'b0001; Nickel = 1;
    tick();
    Cancel = 0; Select = 4'b0000; Nickel = 0;
    check_val("s5_nobuy", Buy, 0);
    check_val("s5_chg20", Change, 20);
    check_val("s5_cv20", ChangeValid, 1);
    check_val("s5_coinrej", CoinReject, 1);
    check_val("s5_busy", Busy, 1);
    tick();
    check_val("s5_money_after", Money, 0);
    check_val("s5_cv_after", ChangeValid, 0);
    check_val("s5_busy_after", Busy, 0);

    // Scenario 6: Reset asserted mid-HOLD acts without a clock edge
    coin(1, 0, 0);
    Select = 4'b0001;
    tick();
    Select = 4'b0000;
    check_val("s6_buy", Buy, 4'b0001);
    tick();
    check_val("s6_in_hold", Busy, 1);
    #3;
    Reset = 1;
    #1;
    check_val("s6_rst_busy", Busy, 0);
    check_val("s6_rst_money", Money, 0);
    check_val("s6_rst_change", Change, 0);
    check_val("s6_rst_buy", Buy, 0);
    #2;
    Reset = 0;
    // Item 2 stock is back to 1 after reset
    coin(0, 1, 0);
    coin(1, 0, 0);
    check_val("s6_credit", Money, 15);
    Select = 4'b0100;
    tick();
    Select = 4'b0000;
    check_val("s6_restock_buy", Buy, 4'b0100);
    check_val("s6_restock_money", Money, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
Front-end controller for the four-item vending datapath. Accumulates coin credit, arbitrates button presses among the four items using round-robin, and issues exactly one single-cycle Buy pulse per accepted purchase. Tracks per-item stock and credit itself, enforces a dispense hold-off, and returns change on cancel. Its Money/Buy outputs drive the purchase datapath directly.

Parameters:
COST0, 5, price of item 0 (cents)
COST1, 10, price of item 1
COST2, 15, price of item 2
COST3, 30, price of item 3
STOCK0..STOCK3, 6/2/1/1, initial stock per item (4-bit)
MAX_CREDIT, 95, credit ceiling (must be <128)
HOLD_CYCLES, 4, dispense hold-off length in cycles (>=1)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  reset, asynchronous, active-high
Nickel  in  1  single-cycle pulse, +5
Dime  in  1  single-cycle pulse, +10
Quarter  in  1  single-cycle pulse, +25
Select  in  4  item request buttons, level, sampled each cycle
Cancel  in  1  single-cycle pulse, request refund
Money  out  7  current credit (registered)
Buy  out  4  one-hot vend pulse, one cycle (registered)
Deny  out  4  pulse: selected item not purchasable this cycle
Change  out  7  refund amount, valid with ChangeValid
ChangeValid  out  1  single-cycle refund strobe
CoinReject  out  1  single-cycle pulse: coin(s) not accepted
Busy  out  1  high in VEND, HOLD, REFUND

Behaviour:
- Reset (async): state=IDLE, Money=0, Buy=0, Deny=0, Change=0, ChangeValid=0, CoinReject=0, Busy=0, stock[i]=STOCKi, rr pointer=3 (item 0 highest priority first).
- States: IDLE, COLLECT, VEND, HOLD, REFUND. All outputs registered.
- Coin sum = 5*Nickel + 10*Dime + 25*Quarter; simultaneous pulses are summed.
- IDLE/COLLECT coin accept: if Money+sum <= MAX_CREDIT, Money += sum, state -> COLLECT; otherwise the whole sum is rejected (Money unchanged) and CoinReject pulses next cycle.
- Coins arriving in VEND/HOLD/REFUND are rejected: CoinReject pulses, no credit.
- Eligible[i] = Select[i] & stock[i]!=0 & Money>=COSTi, evaluated on pre-edge Money (a coin arriving in the same cycle does not count toward that cycle's eligibility).
- COLLECT grant: the first eligible i searching cyclically from pointer+1. On the edge: Buy <= onehot(i), Money <= Money - COSTi (coin in same cycle also added, subject to ceiling check on the result), stock[i]--, pointer <= i, state -> VEND. Latency: Select sampled at edge N, Buy high during cycle N+1.
- Deny[i] pulses (next cycle) for every Select[i] that is set but not eligible in IDLE/COLLECT, including non-granted eligible-but-losing items? No: losers stay unflagged and retry next cycle; only ineligible presses are denied.
- Cancel in COLLECT has priority over grant and coins in the same cycle: state -> REFUND, and those coins are rejected. Cancel in IDLE: no-op. Cancel while Busy: ignored.
- VEND: 1 cycle, Buy cleared on exit, state -> HOLD, hold counter = HOLD_CYCLES-1.
- HOLD: Select ignored (no Deny). When the counter reaches 0: -> COLLECT if Money>0, else IDLE.
- REFUND: 1 cycle, Change = Money, ChangeValid = 1, Money <= 0 on exit, state -> IDLE.
- Stock reaching 0 is permanent until Reset. Money never underflows (grant requires Money>=COST). Busy = state in {VEND, HOLD, REFUND}.
- Reset mid-VEND/HOLD/REFUND: immediate return to reset values, and any pending Change is lost.

Test Plan:
- Reset; Quarter, Dime pulses -> Money=35, state COLLECT; Select=4'b1000 -> Buy=4'b1000 for exactly one cycle, Money=5, Busy high 1+4 cycles, then COLLECT.
- Money=30, Select=4'b0011 held -> Buy=0001 first, then after hold Buy=0010 (round-robin), Money=15.
- Item 2 (stock 1) bought once, credit re-added to 15, Select[2] -> Deny=0100, no Buy, Money unchanged.
- Money=90, Quarter -> CoinReject pulse, Money stays 90; Quarter during HOLD -> CoinReject, Money unchanged.
- Money=20, Cancel with Select=0001 in the same cycle -> no Buy, Change=20 with ChangeValid one cycle, Money=0, IDLE.
- Assert Reset during HOLD -> all outputs 0, stocks restored to 6/2/1/1 immediately, without waiting for a clock edge.
